cache_port_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one DMC_Controller CPU-side interface between two requesters, e.g. instruction fetch and data load/store. It sits between the requesters and the controller's `start_from_CPU_i`, `read_i`, `write_i`, `address_from_CPU_i`, `data_from_CPU_i`, `ready_to_CPU_o` and `data_to_CPU_o` signals. It captures one request, sequences a single start pulse into the controller, waits for completion and returns the data to the winning port. One transaction is in flight at a time.

---
 rtl/cache_port_arbiter_if.sv | 41 ++++
 rtl/cache_port_arbiter.sv | 116 +++++++++++
 tb/tb_cache_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_port_arbiter_if.sv
// Bundle for cache_port_arbiter: the two requester ports and the DMC_Controller CPU-side link.
// slave = arbiter side; master = the requesters plus controller (the testbench side).
interface cache_port_arbiter_if #(
    parameter int BLOCK_SIZE   = 4,
    parameter int ADDRESS_SIZE = 16
);
    // Handshake: a port holds req_valid_i and its payload steady until req_ready_o[p]
    // is high at a rising edge; that edge is the one and only acceptance of the request.
    logic [1:0]              req_valid_i;
    logic [1:0]              req_write_i;
    logic [ADDRESS_SIZE-1:0] req0_address_i;
    logic [ADDRESS_SIZE-1:0] req1_address_i;
    logic [BLOCK_SIZE-1:0]   req0_data_i;
    logic [BLOCK_SIZE-1:0]   req1_data_i;
    logic [1:0]              req_ready_o;
    logic [1:0]              resp_valid_o;
    logic [BLOCK_SIZE-1:0]   resp_data_o;
    logic                    resp_err_o;
    logic                    busy_o;
    logic                    start_o;
    logic                    read_o;
    logic                    write_o;
    logic [ADDRESS_SIZE-1:0] address_o;
    logic [BLOCK_SIZE-1:0]   data_o;
    logic                    ctrl_ready_i;
    logic [BLOCK_SIZE-1:0]   ctrl_data_i;

    modport slave (
        input  req_valid_i, req_write_i, req0_address_i, req1_address_i,
               req0_data_i, req1_data_i, ctrl_ready_i, ctrl_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o, busy_o,
               start_o, read_o, write_o, address_o, data_o
    );

    modport master (
        output req_valid_i, req_write_i, req0_address_i, req1_address_i,
               req0_data_i, req1_data_i, ctrl_ready_i, ctrl_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o, busy_o,
               start_o, read_o, write_o, address_o, data_o
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter sharing one DMC_Controller CPU interface, one transaction in flight.
// Optional BUSY watchdog enabled by defining CACHE_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module cache_port_arbiter #(
    parameter int BLOCK_SIZE     = 4,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    cache_port_arbiter_if.slave  bus,
    output logic [1:0]           state_dbg_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    gnt_q;
    logic                    op_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [BLOCK_SIZE-1:0]   data_q;
    logic [BLOCK_SIZE-1:0]   resp_data_q;
    logic                    gnt_c;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
    logic        err_q;
`endif

    // With both ports valid the winner is the one that did not complete last.
    always_comb begin
        gnt_c = 1'b0;
        case (bus.req_valid_i)
            2'b10:   gnt_c = 1'b1;
            2'b11:   gnt_c = ~last_grant;
            default: gnt_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt_q       <= 1'b0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid_i) begin
                        gnt_q  <= gnt_c;
                        op_q   <= bus.req_write_i[gnt_c];
                        addr_q <= gnt_c ? bus.req1_address_i : bus.req0_address_i;
                        data_q <= gnt_c ? bus.req1_data_i : bus.req0_data_i;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef CACHE_ARB_TIMEOUT_EN
                    cnt   <= '0;
                    err_q <= 1'b0;
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    if (bus.ctrl_ready_i) begin
                        resp_data_q <= bus.ctrl_data_i;
                        last_grant  <= gnt_q;
                        state       <= RESP;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    // Ready on the same edge as expiry takes the branch above.
                    else if (cnt == TIMEOUT_LAST) begin
                        resp_data_q <= '0;
                        err_q       <= 1'b1;
                        last_grant  <= gnt_q;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is held low during reset so a waiting requester cannot see an acceptance.
    assign bus.req_ready_o  = (rst_n_i && state == IDLE && |bus.req_valid_i)
                              ? (gnt_c ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid_o = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.busy_o       = (state != IDLE);
    assign bus.start_o      = (state == ISSUE);
    assign bus.read_o       = (state == ISSUE) && !op_q;
    assign bus.write_o      = (state == ISSUE) && op_q;
    assign bus.address_o    = addr_q;
    assign bus.data_o       = data_q;
    assign state_dbg_o      = state;

`ifdef CACHE_ARB_TIMEOUT_EN
    assign bus.resp_err_o = (state == RESP) && err_q;
`else
    assign bus.resp_err_o = 1'b0;
    // TIMEOUT_CYCLES has no effect without the watchdog; the guard only keeps it referenced.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
    end
`endif
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: vector table of transactions plus reset/timeout sequences.
// A small controller model answers each start pulse after a programmable latency.
module tb_cache_port_arbiter;
    localparam int BS = 4;
    localparam int AS = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         total;
    int         bad;
    int         ctrl_lat;
    logic [BS-1:0] mem [0:255];

    cache_port_arbiter_if #(.BLOCK_SIZE(BS), .ADDRESS_SIZE(AS)) bus ();

    cache_port_arbiter #(
        .BLOCK_SIZE(BS), .ADDRESS_SIZE(AS), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .state_dbg_o(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    // Controller model: data = preloaded memory, answers start after ctrl_lat cycles.
    initial begin
        bus.ctrl_ready_i = 1'b0;
        bus.ctrl_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.start_o) begin
                logic [AS-1:0] a;
                logic          w;
                int            lat;
                a   = bus.address_o;
                w   = bus.write_o;
                lat = ctrl_lat;
                if (w) mem[a[7:0]] = bus.data_o;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (!bus.busy_o) break;
                end
                if (bus.busy_o) begin
                    bus.ctrl_data_i  = w ? 4'hF : mem[a[7:0]];
                    bus.ctrl_ready_i = 1'b1;
                    @(negedge clk);
                    bus.ctrl_ready_i = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver/checker for one accepted transaction; entered in IDLE just after a falling edge.
    task automatic do_txn(input int g, input logic wr, input logic [AS-1:0] addr,
                          input logic [BS-1:0] wdata, input logic [BS-1:0] rdata,
                          input int lat);
        logic [1:0] onehot;
        int         n;
        logic       got;
        logic       hold_bad;
        onehot   = (g == 1) ? 2'b10 : 2'b01;
        ctrl_lat = lat;
        #1;
        check("grant", 32'(bus.req_ready_o), 32'(onehot));
        @(posedge clk);
        #1;
        bus.req_valid_i[g] = 1'b0;
        @(negedge clk);
        #1;
        check("issue_start", 32'(bus.start_o), 32'd1);
        check("issue_op", 32'({bus.read_o, bus.write_o}), 32'({!wr, wr}));
        check("issue_addr", 32'(bus.address_o), 32'(addr));
        check("issue_data", 32'(bus.data_o), 32'(wdata));
        n = 0; got = 1'b0; hold_bad = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.resp_valid_o != 2'b00) begin
                got = 1'b1;
                break;
            end
            if (bus.start_o || bus.read_o || bus.write_o || bus.req_ready_o != 2'b00 ||
                bus.address_o != addr || !bus.busy_o)
                hold_bad = 1'b1;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("busy_hold", 32'(hold_bad), 32'd0);
        check("resp_latency", 32'(n), 32'(lat + 1));
        check("resp_port", 32'(bus.resp_valid_o), 32'(onehot));
        check("resp_err", 32'(bus.resp_err_o), 32'd0);
        if (!wr) check("resp_data", 32'(bus.resp_data_o), 32'(rdata));
        @(negedge clk);
        #1;
        check("back_idle", 32'({bus.busy_o, bus.resp_valid_o}), 32'd0);
    endtask

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    write;
        logic [AS-1:0] a0;
        logic [AS-1:0] a1;
        logic [BS-1:0] d0;
        logic [BS-1:0] d1;
        int            lat;
        int            gnt;
        logic [BS-1:0] rdata;
    } vec_t;

    vec_t tbl [15];

    initial begin
        total = 0;
        bad   = 0;
        ctrl_lat = 1;
        for (int i = 0; i < 256; i++) mem[i] = 4'(i);

        // Expected grants follow round-robin from last_grant=1 after reset.
        tbl[0]  = '{2'b01, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 1, 0, 4'h0};
        tbl[1]  = '{2'b10, 2'b00, 16'h0000, 16'h0002, 4'h0, 4'h3, 2, 1, 4'h2};
        tbl[2]  = '{2'b11, 2'b00, 16'h0001, 16'h0004, 4'h1, 4'h2, 1, 0, 4'h1};
        tbl[3]  = '{2'b11, 2'b00, 16'h0001, 16'h0004, 4'h1, 4'h2, 3, 1, 4'h4};
        tbl[4]  = '{2'b11, 2'b00, 16'h0003, 16'h0005, 4'h5, 4'h6, 1, 0, 4'h3};
        tbl[5]  = '{2'b11, 2'b00, 16'h0003, 16'h0005, 4'h5, 4'h6, 1, 1, 4'h5};
        tbl[6]  = '{2'b11, 2'b00, 16'h0006, 16'h0007, 4'h9, 4'hC, 2, 0, 4'h6};
        tbl[7]  = '{2'b11, 2'b00, 16'h0006, 16'h0007, 4'h9, 4'hC, 2, 1, 4'h7};
        tbl[8]  = '{2'b11, 2'b00, 16'h0008, 16'h0009, 4'h0, 4'h0, 1, 0, 4'h8};
        tbl[9]  = '{2'b11, 2'b00, 16'h0008, 16'h0009, 4'h0, 4'h0, 1, 1, 4'h9};
        tbl[10] = '{2'b10, 2'b10, 16'h0000, 16'h0004, 4'h0, 4'h0, 2, 1, 4'h0};
        tbl[11] = '{2'b10, 2'b00, 16'h0000, 16'h0004, 4'h0, 4'h7, 1, 1, 4'h0};
        tbl[12] = '{2'b11, 2'b01, 16'h0014, 16'h0005, 4'hA, 4'h0, 6, 0, 4'h0};
        tbl[13] = '{2'b10, 2'b00, 16'h0014, 16'h0005, 4'hA, 4'h0, 1, 1, 4'h5};
        tbl[14] = '{2'b01, 2'b00, 16'h0014, 16'h0005, 4'h0, 4'h0, 1, 0, 4'hA};

        rst_n = 1'b0;
        bus.req_valid_i    = 2'b00;
        bus.req_write_i    = 2'b00;
        bus.req0_address_i = '0;
        bus.req1_address_i = '0;
        bus.req0_data_i    = '0;
        bus.req1_data_i    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", 32'({bus.busy_o, bus.start_o, bus.read_o, bus.write_o,
                               bus.resp_valid_o, bus.req_ready_o, bus.resp_err_o}), 32'd0);
        check("rst_bus", 32'({bus.address_o, bus.data_o, bus.resp_data_o}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            bus.req_valid_i    = tbl[i].valid;
            bus.req_write_i    = tbl[i].write;
            bus.req0_address_i = tbl[i].a0;
            bus.req1_address_i = tbl[i].a1;
            bus.req0_data_i    = tbl[i].d0;
            bus.req1_data_i    = tbl[i].d1;
            do_txn(tbl[i].gnt, tbl[i].write[tbl[i].gnt],
                   (tbl[i].gnt == 1) ? tbl[i].a1 : tbl[i].a0,
                   (tbl[i].gnt == 1) ? tbl[i].d1 : tbl[i].d0,
                   tbl[i].rdata, tbl[i].lat);
        end

        // Reset pulsed while BUSY: transaction dropped, arbitration restarts at port 0.
        ctrl_lat = 20;
        bus.req_valid_i    = 2'b10;
        bus.req_write_i    = 2'b00;
        bus.req1_address_i = 16'h0003;
        #1;
        check("mid_grant", 32'(bus.req_ready_o), 32'h2);
        @(posedge clk);
        #1;
        bus.req_valid_i = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("mid_busy", 32'(bus.busy_o), 32'd1);
        bus.req_valid_i    = 2'b11;
        bus.req0_address_i = 16'h0007;
        bus.req1_address_i = 16'h0006;
        bus.req0_data_i    = 4'h1;
        bus.req1_data_i    = 4'h2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 32'({bus.busy_o, bus.start_o, bus.resp_valid_o,
                                   bus.req_ready_o, bus.resp_err_o}), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_noresp", 32'(bus.resp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 16'h0007, 4'h1, 4'h7, 2);
        do_txn(1, 1'b0, 16'h0006, 4'h2, 4'h6, 1);

`ifdef CACHE_ARB_TIMEOUT_EN
        begin
            int n;
            ctrl_lat = 100;
            bus.req_valid_i    = 2'b01;
            bus.req_write_i    = 2'b00;
            bus.req0_address_i = 16'h0002;
            #1;
            check("to_grant", 32'(bus.req_ready_o), 32'h1);
            @(posedge clk);
            #1;
            bus.req_valid_i = 2'b00;
            @(negedge clk);
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                #1;
                n++;
                if (bus.resp_valid_o != 2'b00) break;
            end
            check("to_cycles", 32'(n), 32'd9);
            check("to_port", 32'(bus.resp_valid_o), 32'h1);
            check("to_err", 32'(bus.resp_err_o), 32'd1);
            check("to_data", 32'(bus.resp_data_o), 32'd0);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
